// File: rtl/pe_dot_acc.sv
// Dot-product processing element: LANES signed/unsigned multiplies, a fully
// registered pairwise adder tree, and a saturating frame accumulator.
module pe_dot_acc #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACCW  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_signed,
  input  logic [LANES*DW-1:0]     ifm_in,
  input  logic [LANES*DW-1:0]     wgt_in,
  output logic                    out_valid,
  output logic signed [ACCW-1:0]  out_data,
  output logic                    out_sat
);

  localparam int unsigned L  = $clog2(LANES);
  localparam int unsigned XW = DW + 1;
  localparam int unsigned PW = 2 * DW + 2;
  localparam int unsigned TW = PW + L;
  localparam int unsigned SW = ACCW + 1;

  // Control pipeline: index 0 is stage M, index k is tree level k
  logic [L:0] r_vld;
  logic [L:0] r_fst;
  logic [L:0] r_lst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_fst <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[L-1:0], in_valid};
      r_fst <= {r_fst[L-1:0], in_first};
      r_lst <= {r_lst[L-1:0], in_last};
    end
  end

  // Stage M: operand extension and per-lane products
  logic signed [XW-1:0] w_ifm_x  [LANES];
  logic signed [XW-1:0] w_wgt_x  [LANES];
  logic signed [PW-1:0] w_prod   [LANES];
  logic signed [PW-1:0] r_prod   [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_ifm_x[i] = $signed({in_signed & ifm_in[i*DW + DW - 1], ifm_in[i*DW +: DW]});
      w_wgt_x[i] = $signed({in_signed & wgt_in[i*DW + DW - 1], wgt_in[i*DW +: DW]});
      w_prod[i]  = PW'(w_ifm_x[i]) * PW'(w_wgt_x[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        r_prod[i] <= w_prod[i];
      end
    end
  end

  // Adder tree: level k holds LANES>>k partial sums, one bit wider per level
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned NW = PW + k;
    localparam int unsigned NN = LANES >> k;
    logic signed [NW-1:0] r_sum [NN];

    if (k == 1) begin : g_leaf
      always_ff @(posedge clk) begin
        if (r_vld[0]) begin
          for (int j = 0; j < NN; j++) begin
            r_sum[j] <= $signed({r_prod[2*j][PW-1], r_prod[2*j]})
                      + $signed({r_prod[2*j+1][PW-1], r_prod[2*j+1]});
          end
        end
      end
    end else begin : g_node
      always_ff @(posedge clk) begin
        if (r_vld[k-1]) begin
          for (int j = 0; j < NN; j++) begin
            r_sum[j] <= $signed({g_lvl[k-1].r_sum[2*j][NW-2], g_lvl[k-1].r_sum[2*j]})
                      + $signed({g_lvl[k-1].r_sum[2*j+1][NW-2], g_lvl[k-1].r_sum[2*j+1]});
          end
        end
      end
    end
  end

  logic signed [TW-1:0] w_tree;
  assign w_tree = g_lvl[L].r_sum[0];

  // Stage A: saturating accumulate; overflow shows as differing top two bits
  logic signed [ACCW-1:0] r_acc;
  logic                   r_sat;
  logic [SW-1:0]          w_base;
  logic [SW-1:0]          w_s;
  logic                   w_hi;
  logic                   w_lo;
  logic [ACCW-1:0]        w_acc_next;
  logic                   w_sat_next;

  always_comb begin
    w_base     = '0;
    w_s        = '0;
    w_hi       = 1'b0;
    w_lo       = 1'b0;
    w_acc_next = '0;
    w_sat_next = 1'b0;
    if (!r_fst[L]) begin
      w_base = {r_acc[ACCW-1], r_acc};
    end
    w_s  = w_base + {{(SW-TW){w_tree[TW-1]}}, w_tree};
    w_hi = ~w_s[SW-1] &  w_s[SW-2];
    w_lo =  w_s[SW-1] & ~w_s[SW-2];
    if (w_hi) begin
      w_acc_next = {1'b0, {(ACCW-1){1'b1}}};
    end else if (w_lo) begin
      w_acc_next = {1'b1, {(ACCW-1){1'b0}}};
    end else begin
      w_acc_next = w_s[ACCW-1:0];
    end
    w_sat_next = (~r_fst[L] & r_sat) | w_hi | w_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (r_vld[L]) begin
        if (r_lst[L]) begin
          r_acc     <= '0;
          r_sat     <= 1'b0;
          out_data  <= $signed(w_acc_next);
          out_sat   <= w_sat_next;
          out_valid <= 1'b1;
        end else begin
          r_acc <= $signed(w_acc_next);
          r_sat <= w_sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_dot_acc.sv
// Directed bench for pe_dot_acc (LANES=8, DW=8, ACCW=24) with hand-computed results.
module tb_pe_dot_acc;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACCW  = 24;
  localparam int          LAT   = 5;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic                   in_signed;
  logic [LANES*DW-1:0]    ifm_in;
  logic [LANES*DW-1:0]    wgt_in;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;
  logic                   out_sat;

  pe_dot_acc #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_signed (in_signed),
    .ifm_in    (ifm_in),
    .wgt_in    (wgt_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lc;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled mid-cycle
  int      pq_cyc  [$];
  longint  pq_data [$];
  bit      pq_sat  [$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pq_cyc.push_back(cyc);
      pq_data.push_back(longint'(out_data));
      pq_sat.push_back(out_sat);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit f, input bit l, input bit s,
                       input logic [63:0] ifm, input logic [63:0] wgt);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_first  = f;
    in_last   = l;
    in_signed = s;
    ifm_in    = ifm;
    wgt_in    = wgt;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  // Signed beat whose dot product equals v: lane 0 carries v x 1
  task automatic beat_sum(input bit f, input bit l, input int v);
    logic [7:0] b;
    b = v[7:0];
    drive(1'b1, f, l, 1'b1, {56'h0, b}, 64'h1);
  endtask

  task automatic pop_chk(input string tag, input longint d, input bit s, input int ce);
    if (pq_data.size() > 0) begin
      chk({tag, "_data"}, pq_data.pop_front(), d);
      chk({tag, "_sat"}, longint'(pq_sat.pop_front()), longint'(s));
      if (ce >= 0) chk({tag, "_cyc"}, longint'(pq_cyc.pop_front()), longint'(ce));
      else void'(pq_cyc.pop_front());
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  task automatic expect_n(input string tag, input int n);
    chk({tag, "_count"}, longint'(pq_data.size()), longint'(n));
  endtask

  task automatic clear_q();
    pq_cyc.delete();
    pq_data.delete();
    pq_sat.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_signed = 1'b0;
    ifm_in    = '0;
    wgt_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data",  longint'(out_data), 0);
    chk("rst_sat",   longint'(out_sat), 0);
    rst = 1'b0;
    idle(2);
    clear_q();

    // Single beat, 8 x (1*2), latency check
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0101010101010101, 64'h0202020202020202);
    lc = cyc;
    idle(10);
    expect_n("single", 1);
    pop_chk("single", 16, 1'b0, lc + LAT);

    // Operand extremes
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h8080808080808080, 64'h8080808080808080);
    idle(8);
    expect_n("s_ext", 1);
    pop_chk("s_ext", 131072, 1'b0, -1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    idle(8);
    expect_n("u_ext", 1);
    pop_chk("u_ext", 520200, 1'b0, -1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h807F807F807F807F, 64'h0101010101010101);
    idle(8);
    expect_n("alt", 1);
    pop_chk("alt", -4, 1'b0, -1);

    // Multi-beat frame with bubbles, then back-to-back single frame
    beat_sum(1'b1, 1'b0, 10);
    idle(2);
    beat_sum(1'b0, 1'b0, -3);
    idle(2);
    beat_sum(1'b0, 1'b1, 100);
    lc = cyc;
    beat_sum(1'b0, 1'b1, 5);
    idle(10);
    expect_n("bubble", 2);
    pop_chk("bubble", 107, 1'b0, lc + LAT);
    pop_chk("next", 5, 1'b0, lc + LAT + 1);

    // Positive saturation over 64 beats, then recovery
    for (int i = 0; i < 64; i++)
      drive(1'b1, i == 0, i == 63, 1'b1, 64'h8080808080808080, 64'h8080808080808080);
    beat_sum(1'b1, 1'b1, 7);
    idle(10);
    expect_n("sat_pos", 2);
    pop_chk("sat_pos", 8388607, 1'b1, -1);
    pop_chk("sat_clr", 7, 1'b0, -1);

    // Negative saturation over 65 beats
    for (int i = 0; i < 65; i++)
      drive(1'b1, i == 0, i == 64, 1'b1, 64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F);
    idle(10);
    expect_n("sat_neg", 1);
    pop_chk("sat_neg", -8388608, 1'b1, -1);

    // Reset in the middle of a frame
    beat_sum(1'b1, 1'b0, 20);
    beat_sum(1'b0, 1'b0, 30);
    idle(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_data",  longint'(out_data), 0);
    chk("mid_rst_sat",   longint'(out_sat), 0);
    chk("mid_rst_valid", longint'(out_valid), 0);
    rst = 1'b0;
    idle(8);
    expect_n("mid_rst", 0);
    clear_q();
    beat_sum(1'b1, 1'b1, 9);
    idle(8);
    expect_n("post_rst", 1);
    pop_chk("post_rst", 9, 1'b0, -1);

    // A new first abandons the open frame
    beat_sum(1'b1, 1'b0, 50);
    beat_sum(1'b1, 1'b1, 4);
    idle(10);
    expect_n("refirst", 1);
    pop_chk("refirst", 4, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
